l1_mem_arbiter: RTL
===================

Name: l1_mem_arbiter

Overview:
- Shares one L1-to-bus memory request port between the instruction cache (I-path) and data cache (D-path) of a River core.
- Sits between the icache_lru/dcache request/response interfaces and the core's AXI/L2 bridge.
- Single outstanding transaction. Round-robin grant. Responses are routed back to the owning path.
- Sequences the miss/flush refill traffic produced by the cache state machines (WaitGrant/WaitResp).

Parameters:
- abus, 48, physical address width (CFG_CPU_ADDR_BITS).
- linew, 256, cache line width in bits (L1CACHE_LINE_BITS).
- wdog_bits, 10, watchdog counter width (used only with the optional feature).

Ports:
- i_clk  in  1  clock
- i_nrst  in  1  asynchronous reset, active low
- i_ireq_valid  in  1  I-path request
- o_ireq_ready  out  1  I-path request accepted this cycle
- i_ireq_type  in  3  REQ_MEM_TYPE bits (read/write/cached/unique)
- i_ireq_addr  in  abus  line-aligned address
- i_ireq_size  in  3  log2 bytes
- o_iresp_valid  out  1  I-path response
- o_iresp_data  out  linew  response line
- o_iresp_load_fault  out  1  I-path load fault
- i_dreq_valid, o_dreq_ready, i_dreq_type, i_dreq_addr, i_dreq_size  same as I-path
- i_dreq_wdata  in  linew  D-path write data
- i_dreq_wstrb  in  linew/8  D-path byte strobes
- o_dresp_valid, o_dresp_data, o_dresp_load_fault  same as I-path
- o_dresp_store_fault  out  1  D-path store fault
- o_mem_req_valid  out  1  bus request
- i_mem_req_ready  in  1  bus accepts request
- o_mem_req_path  out  1  0=I, 1=D
- o_mem_req_type  out  3  forwarded type
- o_mem_req_addr  out  abus  forwarded address
- o_mem_req_size  out  3  forwarded size
- o_mem_req_wdata  out  linew  forwarded write data (0 for I-path)
- o_mem_req_wstrb  out  linew/8  forwarded strobes (0 for I-path)
- i_mem_data_valid  in  1  bus response
- i_mem_data  in  linew  response data
- i_mem_load_fault  in  1  response load fault
- i_mem_store_fault  in  1  response store fault

Behaviour:
- State machine with states Idle=0, WaitGrant=1, WaitResp=2.
- Reset: state=Idle, last=0 (I-path), all registered request fields=0, o_mem_req_valid=0. All ready/resp outputs are 0.
- Grant selection in Idle:
  - Only one path valid: that path wins.
  - Both valid: the path opposite to last wins.
- o_xreq_ready=1 combinationally in Idle for the selected path only. Never asserted outside Idle.
- On acceptance:
  - Latch path, type, addr, size, wdata and wstrb (wdata/wstrb zeroed for I-path).
  - Set last=path and go to WaitGrant.
  - o_mem_req_valid rises the next cycle, so request latency is 1 cycle.
- WaitGrant:
  - o_mem_req_valid=1 with all fields held stable until i_mem_req_ready.
  - On i_mem_req_ready go to WaitResp and drop o_mem_req_valid the same edge.
- WaitResp:
  - o_xresp_valid = i_mem_data_valid for the latched path only. Combinational, 0-cycle forward.
  - Data and faults are forwarded the same way. The other path's resp outputs stay 0.
  - o_iresp has no store fault; an I-path store fault is dropped.
  - On i_mem_data_valid go to Idle. A new request is accepted no earlier than the following cycle.
- i_mem_data_valid outside WaitResp is ignored and produces no response.
- Requests that drop valid before ready are legal and leave no state.
- Reset mid-transaction returns to Idle immediately. The in-flight response is discarded.

Optional Feature:
- Macro: RIVER_L1ARB_WATCHDOG_EN.
- When defined:
  - A wdog_bits counter clears on entry to WaitGrant or WaitResp and increments each cycle in those states.
  - On reaching all-ones in WaitResp, emit a one-cycle response to the latched path. Data is 0. The fault is load_fault for read types and store_fault for write types.
  - Then return to Idle.
  - A late i_mem_data_valid is then ignored.
  - WaitGrant never times out.
- When undefined: no counter; WaitResp waits indefinitely.

Test Plan:
- I-only read 0x80001000, ready same cycle, data valid 3 cycles later -> o_ireq_ready at cycle 0, o_mem_req_valid at cycle 1, o_iresp_valid with data at cycle 4, o_dresp_valid stays 0.
- I and D valid together after reset -> D-path granted first (last=0), I-path granted on the first cycle back in Idle; o_mem_req_path sequence 1,0.
- D write 0x80002040, wstrb=all-ones, i_mem_req_ready held low 5 cycles -> o_mem_req_* stable for 6 cycles, o_dreq_ready not re-asserted.
- D read with i_mem_load_fault=1 on response -> o_dresp_load_fault=1 for one cycle, state Idle next cycle.
- i_nrst low during WaitResp, then i_mem_data_valid -> no resp output asserted, o_mem_req_valid=0, next request granted normally.
- With RIVER_L1ARB_WATCHDOG_EN, wdog_bits=4, I read never answered -> o_iresp_valid with load_fault=1 when the counter reaches 15 (16th WaitResp cycle), data 0.

Source files
------------

// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter sharing one L1 memory request port between the I- and D-cache paths.
// Define RIVER_L1ARB_WATCHDOG_EN to add a WaitResp timeout that returns a faulted response.
module l1_mem_arbiter #(
    parameter int abus      = 48,
    parameter int linew     = 256,
    parameter int wdog_bits = 10
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_ireq_valid,
    output logic                 o_ireq_ready,
    input  logic [2:0]           i_ireq_type,
    input  logic [abus-1:0]      i_ireq_addr,
    input  logic [2:0]           i_ireq_size,
    output logic                 o_iresp_valid,
    output logic [linew-1:0]     o_iresp_data,
    output logic                 o_iresp_load_fault,
    input  logic                 i_dreq_valid,
    output logic                 o_dreq_ready,
    input  logic [2:0]           i_dreq_type,
    input  logic [abus-1:0]      i_dreq_addr,
    input  logic [2:0]           i_dreq_size,
    input  logic [linew-1:0]     i_dreq_wdata,
    input  logic [linew/8-1:0]   i_dreq_wstrb,
    output logic                 o_dresp_valid,
    output logic [linew-1:0]     o_dresp_data,
    output logic                 o_dresp_load_fault,
    output logic                 o_dresp_store_fault,
    output logic                 o_mem_req_valid,
    input  logic                 i_mem_req_ready,
    output logic                 o_mem_req_path,
    output logic [2:0]           o_mem_req_type,
    output logic [abus-1:0]      o_mem_req_addr,
    output logic [2:0]           o_mem_req_size,
    output logic [linew-1:0]     o_mem_req_wdata,
    output logic [linew/8-1:0]   o_mem_req_wstrb,
    input  logic                 i_mem_data_valid,
    input  logic [linew-1:0]     i_mem_data,
    input  logic                 i_mem_load_fault,
    input  logic                 i_mem_store_fault
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] WAIT_GRANT = 2'd1;
    localparam logic [1:0] WAIT_RESP  = 2'd2;

    logic [1:0]          r_state;
    logic                r_last;
    logic                r_path;
    logic [2:0]          r_type;
    logic [abus-1:0]     r_addr;
    logic [2:0]          r_size;
    logic [linew-1:0]    r_wdata;
    logic [linew/8-1:0]  r_wstrb;

    logic                w_idle;
    logic                w_sel_d;
    logic                w_accept;
    logic                w_data_resp;
    logic                w_tmo;
    logic                w_resp;
    logic [linew-1:0]    w_resp_data;
    logic                w_resp_lf;
    logic                w_resp_sf;

    assign w_idle   = (r_state == IDLE);
    // With both paths requesting, the one not served last wins.
    assign w_sel_d  = (i_ireq_valid && i_dreq_valid) ? ~r_last : i_dreq_valid;
    assign w_accept = w_idle && (i_ireq_valid || i_dreq_valid);

    assign o_ireq_ready = w_accept && !w_sel_d;
    assign o_dreq_ready = w_accept && w_sel_d;

    assign w_data_resp = (r_state == WAIT_RESP) && i_mem_data_valid;

`ifdef RIVER_L1ARB_WATCHDOG_EN
    logic [wdog_bits-1:0] r_wdog;

    // A real response arriving on the timeout cycle takes priority.
    assign w_tmo = (r_state == WAIT_RESP) && !i_mem_data_valid && (&r_wdog);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_wdog <= '0;
        end else if (w_accept || ((r_state == WAIT_GRANT) && i_mem_req_ready)) begin
            r_wdog <= '0;
        end else if (r_state == WAIT_GRANT || r_state == WAIT_RESP) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end
`else
    assign w_tmo = (wdog_bits < 0);
`endif

    assign w_resp      = w_data_resp || w_tmo;
    assign w_resp_data = w_data_resp ? i_mem_data : '0;
    assign w_resp_lf   = w_data_resp ? i_mem_load_fault  : (w_tmo && !r_type[0]);
    assign w_resp_sf   = w_data_resp ? i_mem_store_fault : (w_tmo && r_type[0]);

    assign o_iresp_valid       = w_resp && !r_path;
    assign o_iresp_data        = r_path ? '0 : w_resp_data;
    assign o_iresp_load_fault  = w_resp_lf && !r_path;
    assign o_dresp_valid       = w_resp && r_path;
    assign o_dresp_data        = r_path ? w_resp_data : '0;
    assign o_dresp_load_fault  = w_resp_lf && r_path;
    assign o_dresp_store_fault = w_resp_sf && r_path;

    assign o_mem_req_valid = (r_state == WAIT_GRANT);
    assign o_mem_req_path  = r_path;
    assign o_mem_req_type  = r_type;
    assign o_mem_req_addr  = r_addr;
    assign o_mem_req_size  = r_size;
    assign o_mem_req_wdata = r_wdata;
    assign o_mem_req_wstrb = r_wstrb;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state <= IDLE;
            r_last  <= 1'b0;
            r_path  <= 1'b0;
            r_type  <= '0;
            r_addr  <= '0;
            r_size  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= WAIT_GRANT;
                        r_last  <= w_sel_d;
                        r_path  <= w_sel_d;
                        r_type  <= w_sel_d ? i_dreq_type : i_ireq_type;
                        r_addr  <= w_sel_d ? i_dreq_addr : i_ireq_addr;
                        r_size  <= w_sel_d ? i_dreq_size : i_ireq_size;
                        r_wdata <= w_sel_d ? i_dreq_wdata : '0;
                        r_wstrb <= w_sel_d ? i_dreq_wstrb : '0;
                    end
                end
                WAIT_GRANT: begin
                    if (i_mem_req_ready) begin
                        r_state <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (w_resp) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
